// File: rtl/axi_lite_regs_if.sv
// rtl/axi_lite_regs_if.sv - AXI-Lite bus bundle with responder and requester views
interface AXI_LITE;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic        wvalid;
    logic        wready;
    logic        wlast;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic        rvalid;
    logic        rready;
    logic        rlast;

    modport slave (
        input  awaddr, awvalid, wdata, wvalid, wlast, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rvalid, rlast
    );

    modport master (
        output awaddr, awvalid, wdata, wvalid, wlast, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rvalid, rlast
    );
endinterface

// File: rtl/axi_lite_regs.sv
// rtl/axi_lite_regs.sv - AXI-Lite responder exposing a bank of 32-bit RW/RO registers
module axi_lite_regs #(
    parameter int                  NUM_REGS = 8,
    parameter logic [NUM_REGS-1:0] RO_MASK  = '0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    AXI_LITE.slave                    axi,
    output logic [32*NUM_REGS-1:0]    reg_q,
    output logic [NUM_REGS-1:0]       reg_wr_pulse,
    output logic [NUM_REGS-1:0]       reg_rd_pulse,
    input  logic [32*NUM_REGS-1:0]    hw_status
);
    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    localparam int         HW_W       = 32 * 64;
    localparam logic [63:0] RO_EXT    = 64'(RO_MASK);
    localparam logic [6:0] NUM_REGS_W = 7'(NUM_REGS);

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;

    logic        ready_en;
    logic        aw_held, w_held;
    logic [5:0]  aw_idx;
    logic [31:0] w_data;
    logic [31:0] bank [64];
    logic [HW_W-1:0] hw_ext;

    logic        aw_fire, w_fire, ar_fire, wr_go;
    logic [5:0]  wr_idx, rd_idx;
    logic [31:0] wr_data, rd_word;
    logic        wr_ok, rd_in_range;
    logic [63:0] wr_onehot, rd_onehot;
    logic        unused_bits;

    assign unused_bits = ^{axi.awaddr[31:8], axi.awaddr[1:0],
                           axi.araddr[31:8], axi.araddr[1:0], axi.wlast};

    assign hw_ext      = HW_W'(hw_status);
    assign wr_idx      = aw_held ? aw_idx : axi.awaddr[7:2];
    assign wr_data     = w_held ? w_data : axi.wdata;
    assign wr_ok       = ({1'b0, wr_idx} < NUM_REGS_W) && !RO_EXT[wr_idx];
    assign wr_onehot   = 64'd1 << wr_idx;
    assign rd_idx      = axi.araddr[7:2];
    assign rd_in_range = {1'b0, rd_idx} < NUM_REGS_W;
    assign rd_onehot   = 64'd1 << rd_idx;
    assign rd_word     = !rd_in_range    ? 32'd0 :
                         RO_EXT[rd_idx]  ? hw_ext[32*rd_idx +: 32] : bank[rd_idx];

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_q
        assign reg_q[32*i +: 32] = RO_EXT[i] ? 32'd0 : bank[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
        end
    end

    // AW and W may land in either order; the write fires once both are in hand
    always_comb begin
        w_next      = w_state;
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        axi.bvalid  = 1'b0;
        aw_fire     = 1'b0;
        w_fire      = 1'b0;
        wr_go       = 1'b0;
        case (w_state)
            W_IDLE: begin
                axi.awready = ready_en && !aw_held;
                axi.wready  = ready_en && !w_held;
                aw_fire     = axi.awvalid && axi.awready;
                w_fire      = axi.wvalid && axi.wready;
                wr_go       = (aw_held || aw_fire) && (w_held || w_fire);
                if (wr_go) w_next = W_RESP;
            end
            W_RESP: begin
                axi.bvalid = 1'b1;
                if (axi.bready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_comb begin
        r_next      = r_state;
        axi.arready = 1'b0;
        axi.rvalid  = 1'b0;
        axi.rlast   = 1'b0;
        ar_fire     = 1'b0;
        case (r_state)
            R_IDLE: begin
                axi.arready = ready_en;
                ar_fire     = axi.arvalid && axi.arready;
                if (ar_fire) r_next = R_DATA;
            end
            R_DATA: begin
                axi.rvalid = 1'b1;
                axi.rlast  = 1'b1;
                if (axi.rready) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en     <= 1'b0;
            aw_held      <= 1'b0;
            w_held       <= 1'b0;
            aw_idx       <= '0;
            w_data       <= '0;
            axi.bresp    <= 2'b00;
            axi.rdata    <= '0;
            reg_wr_pulse <= '0;
            reg_rd_pulse <= '0;
            for (int i = 0; i < 64; i++) bank[i] <= '0;
        end else begin
            ready_en     <= 1'b1;
            reg_wr_pulse <= '0;
            reg_rd_pulse <= '0;
            if (wr_go) begin
                aw_held   <= 1'b0;
                w_held    <= 1'b0;
                axi.bresp <= wr_ok ? 2'b00 : 2'b10;
                if (wr_ok) begin
                    bank[wr_idx] <= wr_data;
                    reg_wr_pulse <= wr_onehot[NUM_REGS-1:0];
                end
            end else begin
                if (aw_fire) begin
                    aw_held <= 1'b1;
                    aw_idx  <= axi.awaddr[7:2];
                end
                if (w_fire) begin
                    w_held <= 1'b1;
                    w_data <= axi.wdata;
                end
            end
            // Bank is read before this edge's write lands, so a same-edge read sees the old value
            if (ar_fire) begin
                axi.rdata    <= rd_word;
                reg_rd_pulse <= rd_in_range ? rd_onehot[NUM_REGS-1:0] : '0;
            end
        end
    end
endmodule

// File: tb/tb_axi_lite_regs.sv
// tb/tb_axi_lite_regs.sv - directed bench for axi_lite_regs
module tb_axi_lite_regs;
    localparam int N = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [32*N-1:0]   reg_q;
    logic [32*N-1:0]   hw_status;
    logic [N-1:0]      reg_wr_pulse;
    logic [N-1:0]      reg_rd_pulse;
    int                n_checks = 0;
    int                n_fail = 0;

    AXI_LITE bus ();

    axi_lite_regs #(.NUM_REGS(N), .RO_MASK(8'h01)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .axi          (bus),
        .reg_q        (reg_q),
        .reg_wr_pulse (reg_wr_pulse),
        .reg_rd_pulse (reg_rd_pulse),
        .hw_status    (hw_status)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
        logic [7:0]  exp_pulse;
    } vec_t;

    vec_t vecs [13];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d,
                             output logic [1:0] resp, output logic [7:0] pulse);
        int n = 0;
        bus.awaddr = a; bus.wdata = d;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b1;
        while (!(bus.awready && bus.wready) && n < 20) begin
            step();
            n++;
        end
        chk1("wr_ready", bus.awready && bus.wready, 1'b1);
        step();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        chk1("wr_bvalid", bus.bvalid, 1'b1);
        resp = bus.bresp;
        pulse = reg_wr_pulse;
        step();
        chk1("wr_bdone", bus.bvalid, 1'b0);
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [7:0] pulse);
        int n = 0;
        bus.araddr = a; bus.arvalid = 1'b1; bus.rready = 1'b1;
        while (!bus.arready && n < 20) begin
            step();
            n++;
        end
        chk1("rd_arready", bus.arready, 1'b1);
        step();
        bus.arvalid = 1'b0;
        chk1("rd_rvalid", bus.rvalid, 1'b1);
        chk1("rd_rlast", bus.rlast, 1'b1);
        d = bus.rdata;
        pulse = reg_rd_pulse;
        step();
        chk1("rd_done", bus.rvalid, 1'b0);
        bus.rready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  resp;
        logic [7:0]  pulse;
        logic [31:0] rd;
        logic [31:0] exp_words [8];

        vecs[0]  = '{0, 32'h00, 32'h0,        32'hCAFE0001, 8'h01};
        vecs[1]  = '{1, 32'h00, 32'h11111111, 32'h2,        8'h00};
        vecs[2]  = '{0, 32'h00, 32'h0,        32'hCAFE0001, 8'h01};
        vecs[3]  = '{0, 32'h08, 32'h0,        32'h12345678, 8'h04};
        vecs[4]  = '{1, 32'h40, 32'hBBBBBBBB, 32'h2,        8'h00};
        vecs[5]  = '{0, 32'h40, 32'h0,        32'h0,        8'h00};
        vecs[6]  = '{1, 32'h0C, 32'h5,        32'h0,        8'h08};
        vecs[7]  = '{0, 32'h0C, 32'h0,        32'h5,        8'h08};
        vecs[8]  = '{1, 32'h1F, 32'h77,       32'h0,        8'h80};
        vecs[9]  = '{0, 32'h1C, 32'h0,        32'h77,       8'h80};
        vecs[10] = '{1, 32'h104, 32'h0BADF00D, 32'h0,       8'h02};
        vecs[11] = '{0, 32'h07, 32'h0,        32'h0BADF00D, 8'h02};
        vecs[12] = '{0, 32'hFC, 32'h0,        32'h0,        8'h00};
        exp_words = '{32'h0, 32'h0BADF00D, 32'h12345678, 32'h5, 32'h0, 32'h0, 32'h0, 32'h77};

        rst_n = 1'b0;
        bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wvalid = 1'b0; bus.wlast = 1'b1;
        bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
        hw_status = '0;
        hw_status[31:0] = 32'hCAFE0001;
        hw_status[63:32] = 32'h99999999;

        repeat (3) step();
        chk1("rst_awready", bus.awready, 1'b0);
        chk1("rst_wready", bus.wready, 1'b0);
        chk1("rst_arready", bus.arready, 1'b0);
        chk1("rst_bvalid", bus.bvalid, 1'b0);
        chk1("rst_rvalid", bus.rvalid, 1'b0);
        chk("rst_rdata", bus.rdata, 32'h0);
        chk("rst_reg_q_lo", reg_q[31:0] | reg_q[63:32] | reg_q[255:224], 32'h0);
        chk("rst_pulses", {16'h0, reg_wr_pulse, reg_rd_pulse}, 32'h0);
        rst_n = 1'b1;
        chk1("rel_awready_pre", bus.awready, 1'b0);
        step();
        chk1("rel_awready", bus.awready, 1'b1);
        chk1("rel_wready", bus.wready, 1'b1);
        chk1("rel_arready", bus.arready, 1'b1);

        // AW and W in the same cycle
        bus.awaddr = 32'h04; bus.wdata = 32'hDEADBEEF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b1;
        step();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        chk1("t1_bvalid", bus.bvalid, 1'b1);
        chk("t1_bresp", 32'(bus.bresp), 32'h0);
        chk("t1_word1", reg_q[63:32], 32'hDEADBEEF);
        chk("t1_wr_pulse", 32'(reg_wr_pulse), 32'h02);
        step();
        chk("t1_wr_pulse_off", 32'(reg_wr_pulse), 32'h00);
        chk1("t1_bvalid_off", bus.bvalid, 1'b0);

        // W at cycle 0, AW at cycle 3
        bus.wdata = 32'h12345678; bus.wvalid = 1'b1;
        step();
        bus.wvalid = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            chk1("t2_wready_low", bus.wready, 1'b0);
            chk1("t2_bvalid_low", bus.bvalid, 1'b0);
            if (c == 3) begin
                bus.awaddr = 32'h08;
                bus.awvalid = 1'b1;
            end
            step();
        end
        bus.awvalid = 1'b0;
        chk1("t2_bvalid", bus.bvalid, 1'b1);
        chk("t2_bresp", 32'(bus.bresp), 32'h0);
        chk("t2_word2", reg_q[95:64], 32'h12345678);
        step();

        // Read with rready held low for 5 cycles
        bus.araddr = 32'h04; bus.arvalid = 1'b1; bus.rready = 1'b0;
        step();
        bus.arvalid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk1("t3_rvalid", bus.rvalid, 1'b1);
            chk1("t3_rlast", bus.rlast, 1'b1);
            chk("t3_rdata", bus.rdata, 32'hDEADBEEF);
            chk1("t3_arready", bus.arready, 1'b0);
            chk("t3_rd_pulse", 32'(reg_rd_pulse), (k == 0) ? 32'h02 : 32'h00);
            if (k < 4) step();
        end
        bus.rready = 1'b1;
        step();
        chk1("t3_rvalid_off", bus.rvalid, 1'b0);
        bus.rready = 1'b0;

        for (int i = 0; i < 13; i++) begin
            if (vecs[i].wr) begin
                axi_write(vecs[i].addr, vecs[i].data, resp, pulse);
                chk($sformatf("vec%0d_bresp", i), 32'(resp), vecs[i].exp);
                chk($sformatf("vec%0d_wr_pulse", i), 32'(pulse), 32'(vecs[i].exp_pulse));
            end else begin
                axi_read(vecs[i].addr, rd, pulse);
                chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp);
                chk($sformatf("vec%0d_rd_pulse", i), 32'(pulse), 32'(vecs[i].exp_pulse));
            end
        end
        for (int i = 0; i < 8; i++)
            chk($sformatf("bank_word%0d", i), reg_q[32*i +: 32], exp_words[i]);

        // Concurrent write and read of 0x0C on the same edge
        bus.awaddr = 32'h0C; bus.wdata = 32'hAAAA0000; bus.araddr = 32'h0C;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.arvalid = 1'b1;
        bus.bready = 1'b1; bus.rready = 1'b1;
        step();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        chk1("t6_rvalid", bus.rvalid, 1'b1);
        chk("t6_rdata_old", bus.rdata, 32'h5);
        chk1("t6_bvalid", bus.bvalid, 1'b1);
        step();
        bus.rready = 1'b0;
        axi_read(32'h0C, rd, pulse);
        chk("t6_rdata_new", rd, 32'hAAAA0000);

        // Reset while a write response is pending
        bus.awaddr = 32'h10; bus.wdata = 32'h1;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b0;
        step();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        chk1("t7_bvalid_pending", bus.bvalid, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk1("t7_bvalid_reset", bus.bvalid, 1'b0);
        chk("t7_word4_cleared", reg_q[159:128], 32'h0);
        rst_n = 1'b1;
        bus.bready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            chk1("t7_no_resp", bus.bvalid, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/axi_lite_regs.md
# axi_lite_regs

AXI-Lite responder that terminates one downstream port of the system AXI-Lite interconnect and exposes a bank of 32-bit registers to peripheral logic (LED, UART, Ethernet control). It accepts write-address, write-data and read-address transfers, updates or reads the register bank, and returns write responses and read data with full valid/ready handshaking. The block sees window-relative addresses, because the interconnect has already subtracted the peripheral base address.

## Interface
- NUM_REGS, 8 — number of 32-bit registers, 1..64; occupies byte offsets 0x00..(4*NUM_REGS-4) of the 256-byte window
- RO_MASK, 0 — NUM_REGS-bit mask; bit i set makes register i read-only, returning hw_status word i
- clk  in  1  system clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- axi  AXI_LITE.slave  —  awaddr/awvalid/awready, wdata/wvalid/wready/wlast, bresp/bvalid/bready, araddr/arvalid/arready, rdata/rvalid/rready/rlast
- reg_q  out  32*NUM_REGS  current register contents, word i at [32*i+31:32*i]; RO words read 0
- reg_wr_pulse  out  NUM_REGS  one-cycle pulse on the cycle after register i is written
- reg_rd_pulse  out  NUM_REGS  one-cycle pulse on the cycle after a read of register i is accepted; used for clear-on-read and FIFO pop
- hw_status  in  32*NUM_REGS  status words returned for RO registers

## Operation
- Decode: index = addr[7:2]; addr[1:0] ignored; addr[31:8] ignored. index >= NUM_REGS is out of range.
- Write FSM states: W_IDLE, W_RESP.
  - In W_IDLE: awready = 1 while no address is latched; wready = 1 while no data is latched. AW and W are accepted independently, in either order or in the same cycle.
  - At the edge where both address and data are held, perform the write and go to W_RESP.
  - A write is applied only for an in-range, RW index. Out-of-range or RO index: bank unchanged, no pulse, bresp = 2'b10 (SLVERR). Otherwise bresp = 2'b00.
  - wlast is ignored; every beat is a single transfer.
  - W_RESP: bvalid = 1, awready = wready = 0. On bvalid && bready, return to W_IDLE with the latches cleared.
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE: arready = 1. On arvalid && arready, register rdata from the bank or hw_status at that edge, then go to R_DATA. Out-of-range index gives rdata = 0.
  - R_DATA: rvalid = 1, rlast = 1, arready = 0. rdata is held stable. On rready, return to R_IDLE.
- Read and write paths are fully independent and may run concurrently.

## Timing
- Reset (rst_n low, asynchronous): all registers 0, both FSMs idle, latches cleared. Outputs: awready = wready = arready = 0 while reset is asserted, then 1 from the first clock after deassertion. bvalid = rvalid = rlast = 0, bresp = 0, rdata = 0, pulses = 0.
- Reset mid-transaction aborts it. No response is issued for the aborted transfer.
- Write latency: bvalid asserts on the cycle after the later of the AW and W handshakes. reg_q updates and reg_wr_pulse fire in that same cycle.
- Read latency: rvalid asserts on the cycle after the AR handshake. reg_rd_pulse fires in that same cycle.
- Minimum throughput, bready and rready held high: one write per 2 cycles and one read per 2 cycles.
- Simultaneous read and write of the same register: the read returns the pre-write value if its AR handshake is on the same edge as the write, or an earlier one.
- bvalid and rvalid never drop without the matching ready. bresp and rdata are stable while valid is high.
- hw_status is sampled only at the AR handshake edge.

## Test plan
- Reset then write 0xDEADBEEF to offset 0x04, with AW and W in the same cycle and bready high:
  - bvalid one cycle later with bresp = 00
  - reg_q word 1 = 0xDEADBEEF
  - reg_wr_pulse = 0b00000010 for exactly one cycle
- W before AW: wdata 0x12345678 at cycle 0, awaddr 0x08 at cycle 3:
  - wready low from cycle 1 to cycle 3
  - bvalid at cycle 4
  - word 2 = 0x12345678
- Read back offset 0x04 with rready held low for 5 cycles:
  - rvalid and rlast high and rdata = 0xDEADBEEF, stable for all 5 cycles
  - arready low throughout
  - reg_rd_pulse bit 1 pulses once
- RO_MASK = 0x01, hw_status word 0 = 0xCAFE0001:
  - read 0x00 returns 0xCAFE0001
  - write 0x00 returns bresp = 10, reg_q unchanged, no wr pulse
- Out-of-range access to offset 0x40 with NUM_REGS = 8:
  - write returns bresp = 10 and the bank is unchanged
  - read returns rdata = 0
- Concurrent write 0xAAAA0000 and read of offset 0x0C on the same edge, old value 0x5:
  - read returns 0x5
  - a following read returns 0xAAAA0000
- Optional: assert rst_n low while bvalid is high:
  - bvalid = 0 immediately
  - no response after release
